// File: rtl/sdram_demo_nios2_cpu_debug_pkg.sv
// Shared definitions for the Nios II debug on-chip memory engine:
// jdo field positions, engine FSM states and control-register bits.
package sdram_demo_nios2_cpu_debug_pkg;

  localparam int JDO_W         = 38;
  localparam int JDO_CLR       = 36;
  localparam int JDO_LDADDR    = 35;
  localparam int JDO_RD        = 34;
  localparam int JDO_GO        = 23;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_LSB = 3;

  localparam int CTRL_RDY = 0;
  localparam int CTRL_ERR = 1;
  localparam int CTRL_GO  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_JRD,
    S_JCAP,
    S_JWR,
    S_CRD
  } ocimem_state_e;

endpackage

// File: rtl/sdram_demo_nios2_cpu_debug_ocimem_ram.sv
// Single-port debug RAM with byte enables and a one-cycle registered read.
// Contents and read register are deliberately left unreset.
module sdram_demo_nios2_cpu_debug_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/sdram_demo_nios2_cpu_debug_ocimem.sv
// Debug on-chip memory engine: JTAG-driven reads/writes of the debug RAM,
// monitor control bits, and the CPU debug-monitor Avalon slave port.
import sdram_demo_nios2_cpu_debug_pkg::*;

module sdram_demo_nios2_cpu_debug_ocimem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go
);

  ocimem_state_e state_q, state_d;

  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [DATA_W-1:0] mon_d_q, mon_d_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              go_q, go_d;
  logic              ovr_q, ovr_d;
  logic              inc_q, inc_d;
  logic              rst_done_q;

  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  logic              pulse_b;
  logic              pulse_na;
  logic              pulse_a;
  logic              pulse_any;
  logic              sel_ctrl;
  logic [DATA_W-1:0] ctrl_word;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1], jdo[JDO_WDATA_LSB-1:0]};

  // Lower-priority pulses in the same cycle are discarded
  assign pulse_b   = take_action_ocimem_b;
  assign pulse_na  = take_no_action_ocimem_a & ~take_action_ocimem_b;
  assign pulse_a   = take_action_ocimem_a & ~take_no_action_ocimem_a
                   & ~take_action_ocimem_b;
  assign pulse_any = pulse_b | pulse_na | pulse_a;
  assign sel_ctrl  = avs_address[ADDR_W];

  always_comb begin
    ctrl_word           = '0;
    ctrl_word[CTRL_RDY] = rdy_q;
    ctrl_word[CTRL_ERR] = err_q | ovr_q;
    ctrl_word[CTRL_GO]  = go_q;
  end

  always_comb begin
    state_d         = state_q;
    mon_a_d         = mon_a_q;
    mon_d_d         = mon_d_q;
    wdata_d         = wdata_q;
    rdy_d           = rdy_q;
    err_d           = err_q;
    go_d            = go_q;
    ovr_d           = ovr_q;
    inc_d           = inc_q;
    ram_we          = 1'b0;
    ram_be          = '0;
    ram_addr        = mon_a_q;
    ram_wdata       = wdata_q;
    avs_readdata    = '0;
    avs_waitrequest = ~rst_done_q | pulse_any;

    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          pulse_b: begin
            wdata_d = jdo[JDO_WDATA_LSB +: DATA_W];
            state_d = S_JWR;
          end
          pulse_na: begin
            inc_d   = 1'b1;
            state_d = S_JRD;
          end
          pulse_a: begin
            if (jdo[JDO_LDADDR]) mon_a_d = jdo[JDO_ADDR_LSB +: ADDR_W];
            if (jdo[JDO_GO]) go_d = 1'b1;
            if (jdo[JDO_CLR]) begin
              rdy_d = 1'b0;
              err_d = 1'b0;
              ovr_d = 1'b0;
            end
            if (jdo[JDO_RD]) begin
              inc_d   = 1'b0;
              state_d = S_JRD;
            end
          end
          default: begin
            if (rst_done_q && avs_read && !sel_ctrl) begin
              ram_addr        = avs_address[ADDR_W-1:0];
              avs_waitrequest = 1'b1;
              state_d         = S_CRD;
            end else if (rst_done_q && avs_read) begin
              avs_readdata = ctrl_word;
              go_d         = 1'b0;
            end else if (rst_done_q && avs_write && !sel_ctrl) begin
              ram_we    = 1'b1;
              ram_be    = avs_byteenable;
              ram_addr  = avs_address[ADDR_W-1:0];
              ram_wdata = avs_writedata;
            end else if (rst_done_q && avs_write) begin
              rdy_d = avs_writedata[CTRL_RDY];
              err_d = avs_writedata[CTRL_ERR];
            end
          end
        endcase
      end
      S_JRD: begin
        avs_waitrequest = 1'b1;
        state_d         = S_JCAP;
      end
      S_JCAP: begin
        avs_waitrequest = 1'b1;
        mon_d_d         = ram_q;
        if (inc_q) mon_a_d = mon_a_q + 1'b1;
        state_d         = S_IDLE;
      end
      S_JWR: begin
        avs_waitrequest = 1'b1;
        ram_we          = 1'b1;
        ram_be          = '1;
        mon_a_d         = mon_a_q + 1'b1;
        state_d         = S_IDLE;
      end
      S_CRD: begin
        avs_readdata = ram_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Busy engine drops the command and latches a sticky overrun
    if (state_q != S_IDLE && pulse_any) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      wdata_q    <= '0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      go_q       <= 1'b0;
      ovr_q      <= 1'b0;
      inc_q      <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      wdata_q    <= wdata_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      go_q       <= go_d;
      ovr_q      <= ovr_d;
      inc_q      <= inc_d;
      rst_done_q <= 1'b1;
    end
  end

  sdram_demo_nios2_cpu_debug_ocimem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  assign MonDReg       = mon_d_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q | ovr_q;
  assign monitor_go    = go_q;

endmodule
